// File: rtl/controle_cifra.sv
// Round-sequencing controller for an iterated 128-bit block cipher.
// It holds the running state, steps an external round unit and hands the ciphertext off.
module controle_cifra #(
  parameter int NUM_RODADAS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         entrada_valida,
  output logic         entrada_pronta,
  input  logic [127:0] bloco_entrada,
  input  logic [127:0] chave_inicial,
  input  logic         abortar,
  output logic [3:0]   rodada_atual,
  output logic         ultima_rodada,
  output logic [127:0] bloco_rodada,
  input  logic [127:0] saida_rodada,
  output logic         saida_valida,
  input  logic         saida_pronta,
  output logic [127:0] bloco_saida,
  output logic         ocupado,
  output logic [15:0]  blocos_cifrados
);

  typedef enum logic [1:0] {OCIOSO, RODADA, FIM} fsm_t;

  localparam logic [3:0] ULTIMA = 4'(NUM_RODADAS);

  fsm_t         fsm, fsm_next;
  logic [127:0] estado;
  logic [3:0]   rodada;
  logic [15:0]  contador;

  // Datapath updates follow the current state; the abort checks keep them in step with fsm_next.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= OCIOSO;
      estado   <= '0;
      rodada   <= '0;
      contador <= '0;
    end else begin
      fsm <= fsm_next;
      case (fsm)
        OCIOSO: begin
          if (entrada_valida) begin
            estado <= bloco_entrada ^ chave_inicial;
            rodada <= 4'd1;
          end
        end
        RODADA: begin
          if (!abortar) begin
            estado <= saida_rodada;
            if (rodada != ULTIMA)
              rodada <= rodada + 4'd1;
          end
        end
        FIM: begin
          if (saida_pronta && !abortar)
            contador <= contador + 16'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      OCIOSO: if (entrada_valida) fsm_next = RODADA;
      RODADA: begin
        if (abortar)
          fsm_next = OCIOSO;
        else if (rodada == ULTIMA)
          fsm_next = FIM;
      end
      FIM: if (abortar || saida_pronta) fsm_next = OCIOSO;
      default: fsm_next = OCIOSO;
    endcase
  end

  always_comb begin
    entrada_pronta = (fsm == OCIOSO);
    ocupado        = (fsm != OCIOSO);
    rodada_atual   = (fsm == RODADA) ? rodada : 4'd0;
    ultima_rodada  = (fsm == RODADA) && (rodada == ULTIMA);
    saida_valida   = (fsm == FIM);
    bloco_saida    = (fsm == FIM) ? estado : '0;
  end

  assign bloco_rodada    = estado;
  assign blocos_cifrados = contador;

endmodule

// File: doc/controle_cifra.md
CONTROLE_CIFRA -- requirements
Module: controle_cifra

Interface
REQ-001 SHALL have parameter NUM_RODADAS, default 10, giving the number of rounds per block (range 1..15).
REQ-002 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port entrada_valida, input, 1, which marks a new block as offered.
REQ-005 SHALL have port entrada_pronta, output, 1, which indicates the controller accepts a block this cycle.
REQ-006 SHALL have port bloco_entrada, input, 128, carrying the plaintext block.
REQ-007 SHALL have port chave_inicial, input, 128, carrying round key 0, sampled at acceptance.
REQ-008 SHALL have port abortar, input, 1, which discards the block in flight.
REQ-009 SHALL have port rodada_atual, output, 4, the round index driven to the external round unit.
REQ-010 SHALL have port ultima_rodada, output, 1, which tells the round unit to skip column mixing.
REQ-011 SHALL have port bloco_rodada, output, 128, the state register presented to the round unit.
REQ-012 SHALL have port saida_rodada, input, 128, the round unit's combinational result.
REQ-013 SHALL have port saida_valida, output, 1, which marks the ciphertext as valid.
REQ-014 SHALL have port saida_pronta, input, 1, asserted when the consumer accepts the ciphertext.
REQ-015 SHALL have port bloco_saida, output, 128, carrying the ciphertext.
REQ-016 SHALL have port ocupado, output, 1, high in any state other than OCIOSO.
REQ-017 SHALL have port blocos_cifrados, output, 16, a count of completed blocks.

Function
REQ-018 SHALL implement FSM states OCIOSO, RODADA and FIM, with a 128-bit state register `estado` and a 4-bit round counter `rodada`.
REQ-019 SHALL assert entrada_pronta only in OCIOSO; acceptance occurs when entrada_valida and entrada_pronta are both high at a clock edge.
REQ-020 On acceptance, SHALL set estado to bloco_entrada XOR chave_inicial, rodada to 1, and the FSM to RODADA.
REQ-021 In RODADA, on each edge, SHALL set estado to saida_rodada; if rodada equals NUM_RODADAS it SHALL go to FIM, otherwise it SHALL increment rodada.
REQ-022 SHALL drive rodada_atual to rodada in RODADA and to 0 otherwise.
REQ-023 SHALL drive ultima_rodada as (state RODADA) AND (rodada equals NUM_RODADAS).
REQ-024 SHALL drive bloco_rodada from estado at all times.
REQ-025 In FIM, SHALL hold saida_valida at 1 and bloco_saida at estado, both stable until saida_pronta is sampled high.
REQ-026 When in FIM with saida_pronta high, SHALL go to OCIOSO and increment blocos_cifrados, wrapping from 0xFFFF to 0.
REQ-027 Latency: with acceptance at edge k, saida_valida SHALL first be high after edge k+NUM_RODADAS; throughput is at most 1 block per NUM_RODADAS+2 cycles.
REQ-028 When abortar is high in RODADA or FIM, SHALL go to OCIOSO at the next edge, with no saida_valida and no counter increment; abortar SHALL be ignored in OCIOSO.
REQ-029 When abortar and saida_pronta are both high in FIM, abortar SHALL win and the counter SHALL NOT increment.
REQ-030 SHALL drive bloco_saida to 0 whenever saida_valida is 0.

Reset
REQ-031 When rst is high at an edge, the FSM SHALL go to OCIOSO and estado, rodada and blocos_cifrados SHALL be cleared to 0, in every state.
REQ-032 rst SHALL take priority over acceptance, abortar and saida_pronta.
REQ-033 Output values after reset SHALL be: entrada_pronta 1, saida_valida 0, ocupado 0, rodada_atual 0, ultima_rodada 0, bloco_saida 0, bloco_rodada 0, blocos_cifrados 0.

Verification
REQ-034 Reset: hold rst for 2 cycles -> all outputs at their reset values; entrada_pronta is 1 on the first cycle after reset.
REQ-035 Incrementing stub (saida_rodada = bloco_rodada + 1), bloco_entrada 0, chave_inicial 0 -> rodada_atual steps 1..10 with ultima_rodada high only at 10; bloco_saida 0x0A appears 10 cycles after acceptance; blocos_cifrados reads 1.
REQ-036 Backpressure: saida_pronta held low for 5 cycles while in FIM -> saida_valida and bloco_saida stable, entrada_pronta 0; saida_pronta pulsed -> OCIOSO on the next cycle.
REQ-037 Abort: abortar asserted while rodada_atual is 4 -> OCIOSO on the next cycle, saida_valida never asserts, blocos_cifrados unchanged; a new block is then accepted normally.
REQ-038 Reset mid-operation: rst asserted at round 6 -> same values as REQ-033, and blocos_cifrados is 0.
REQ-039 Real round unit with AES-128 key expansion, plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> bloco_saida 69c4e0d86a7b0430d8cdb78070b4c55a.
